// File: rtl/antidroop_iir_mc.sv
`default_nettype none
// ==========================================================================
// antidroop_iir_mc - multi-channel saturating anti-droop IIR compensator
// Revision 1.0
// ==========================================================================
module antidroop_iir_mc #(
  parameter int CH    = 2,
  parameter int DW    = 16,
  parameter int TW    = 7,
  parameter int SCALE = 15,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CH*DW-1:0] din,
  input  logic [CH*TW-1:0] tapWeight,
  input  logic             trig,
  input  logic             accClr_en,
  input  logic             hold,
  input  logic             bypass,
  input  logic             oflow_clr,
  output logic [CH-1:0]    oflowDetect,
  output logic [CH*DW-1:0] dout
);

  localparam int PW = DW + TW;
  // Accumulator bits from here upward must all match the sign for the scaled value to fit DW
  localparam int OB = SCALE + DW - 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [DW-1:0]    OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0]    OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  logic             trig_a;
  logic             trig_b;
  logic [CH*TW-1:0] tw_a;
  logic [CH*TW-1:0] tw_b;
  logic             acc_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_a <= 1'b0;
      trig_b <= 1'b0;
      tw_a   <= '0;
      tw_b   <= '0;
    end else begin
      trig_a <= trig;
      trig_b <= trig_a;
      tw_a   <= tapWeight;
      tw_b   <= tw_a;
    end
  end

  assign acc_clr = trig_a & ~trig_b & accClr_en;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DW-1:0]    din_c;
    logic signed [DW-1:0]    din_d;
    logic signed [DW-1:0]    corr;
    logic signed [DW-1:0]    dout_q;
    logic signed [DW-1:0]    dout_nx;
    logic signed [TW-1:0]    w_c;
    logic signed [PW-1:0]    mult;
    logic signed [ACC_W:0]   acc_wide;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sat;
    logic signed [DW:0]      sum;
    logic                    oflow;
    logic                    sum_clamp;
    logic                    flag_set;
    logic                    flag;

    assign din_c    = din[c*DW +: DW];
    assign w_c      = tw_b[c*TW +: TW];
    assign acc_wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PW){mult[PW-1]}}, mult};
    assign acc_sat  = (acc_wide[ACC_W] == acc_wide[ACC_W-1]) ? acc_wide[ACC_W-1:0]
                    : (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX);
    assign oflow     = ~((&acc[ACC_W-1:OB]) | ~(|acc[ACC_W-1:OB]));
    assign corr      = acc[OB:SCALE];
    assign sum       = {din_d[DW-1], din_d} + {corr[DW-1], corr};
    assign sum_clamp = sum[DW] ^ sum[DW-1];
    assign flag_set  = ~bypass & (oflow | sum_clamp);

    always_comb begin
      dout_nx = sum[DW-1:0];
      if (bypass) begin
        dout_nx = din_d;
      end else if (oflow) begin
        dout_nx = acc[ACC_W-1] ? OUT_MIN : OUT_MAX;
      end else if (sum_clamp) begin
        dout_nx = sum[DW] ? OUT_MIN : OUT_MAX;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        din_d  <= '0;
        mult   <= '0;
        acc    <= '0;
        dout_q <= '0;
        flag   <= 1'b0;
      end else begin
        din_d  <= din_c;
        mult   <= PW'(din_c) * PW'(w_c);
        dout_q <= dout_nx;
        // Clear beats hold; a new set condition beats the sticky-flag clear
        if (acc_clr) begin
          acc <= '0;
        end else if (!hold) begin
          acc <= acc_sat;
        end
        if (flag_set) begin
          flag <= 1'b1;
        end else if (oflow_clr) begin
          flag <= 1'b0;
        end
      end
    end

    assign dout[c*DW +: DW] = dout_q;
    assign oflowDetect[c]   = flag;
  end

endmodule
`default_nettype wire

// File: tb/tb_antidroop_iir_mc.sv
`default_nettype none
// ==========================================================================
// tb_antidroop_iir_mc - vector table, corner sequences and random vs model
// Revision 1.0
// ==========================================================================
module tb_antidroop_iir_mc;

  localparam int CH  = 2;
  localparam int TW  = 7;
  localparam int DWA = 16;
  localparam int DWB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               trig, accClr_en, hold, bypass, oflow_clr;
  logic [CH*DWA-1:0]  din_a, dout_a;
  logic [CH*DWB-1:0]  din_b, dout_b;
  logic [CH*TW-1:0]   tw_a_in, tw_b_in;
  logic [CH-1:0]      ofl_a, ofl_b;

  antidroop_iir_mc #(.CH(CH), .DW(16), .TW(TW), .SCALE(15), .ACC_W(48)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .tapWeight(tw_a_in), .trig(trig),
    .accClr_en(accClr_en), .hold(hold), .bypass(bypass), .oflow_clr(oflow_clr),
    .oflowDetect(ofl_a), .dout(dout_a));

  // Narrow instance so the accumulator reaches its clamp within a short run
  antidroop_iir_mc #(.CH(CH), .DW(8), .TW(TW), .SCALE(4), .ACC_W(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .tapWeight(tw_b_in), .trig(trig),
    .accClr_en(accClr_en), .hold(hold), .bypass(bypass), .oflow_clr(oflow_clr),
    .oflowDetect(ofl_b), .dout(dout_b));

  int n_chk = 0;
  int n_fail = 0;

  function automatic int p_dw(input int i);  return (i == 0) ? 16 : 8;  endfunction
  function automatic int p_sc(input int i);  return (i == 0) ? 15 : 4;  endfunction
  function automatic int p_aw(input int i);  return (i == 0) ? 48 : 20; endfunction

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction
  function automatic longint smax(input int w); return (longint'(1) << (w - 1)) - 1; endfunction
  function automatic longint smin(input int w); return -(longint'(1) << (w - 1));    endfunction
  function automatic longint sat(input longint v, input int w);
    if (v > smax(w)) return smax(w);
    if (v < smin(w)) return smin(w);
    return v;
  endfunction

  function automatic longint in_din(input int i, input int c);
    if (i == 0) return sx(longint'(din_a >> (c * DWA)), DWA);
    return sx(longint'(din_b >> (c * DWB)), DWB);
  endfunction
  function automatic longint in_tw(input int i, input int c);
    if (i == 0) return sx(longint'(tw_a_in >> (c * TW)), TW);
    return sx(longint'(tw_b_in >> (c * TW)), TW);
  endfunction
  function automatic longint dut_dout(input int i, input int c);
    if (i == 0) return sx(longint'(dout_a >> (c * DWA)), DWA);
    return sx(longint'(dout_b >> (c * DWB)), DWB);
  endfunction
  function automatic longint dut_flag(input int i, input int c);
    return (i == 0) ? longint'(ofl_a[c]) : longint'(ofl_b[c]);
  endfunction

  // Reference model: the signal chain as plain integer arithmetic
  longint m_dind [2][CH];
  longint m_mult [2][CH];
  longint m_acc  [2][CH];
  longint m_dout [2][CH];
  longint m_twa  [2][CH];
  longint m_twb  [2][CH];
  bit     m_flag [2][CH];
  bit     m_ta, m_tb;

  task automatic model_reset();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin
        m_dind[i][c] = 0; m_mult[i][c] = 0; m_acc[i][c] = 0; m_dout[i][c] = 0;
        m_twa[i][c] = 0;  m_twb[i][c] = 0;  m_flag[i][c] = 1'b0;
      end
    m_ta = 1'b0;
    m_tb = 1'b0;
  endtask

  task automatic model_step();
    bit     edge_now, ofl, clampv;
    longint acc, hi, sum;
    int     dw, sc;
    edge_now = m_ta && !m_tb;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin
        dw  = p_dw(i);
        sc  = p_sc(i);
        acc = m_acc[i][c];
        hi  = acc >>> (sc + dw - 1);
        ofl = (hi != 0) && (hi != -1);
        sum = m_dind[i][c] + (acc >>> sc);
        clampv = (sum > smax(dw)) || (sum < smin(dw));
        if (bypass)   m_dout[i][c] = m_dind[i][c];
        else if (ofl) m_dout[i][c] = (acc >= 0) ? smax(dw) : smin(dw);
        else          m_dout[i][c] = sat(sum, dw);
        if (!bypass && (ofl || clampv)) m_flag[i][c] = 1'b1;
        else if (oflow_clr)             m_flag[i][c] = 1'b0;
        if (edge_now && accClr_en) m_acc[i][c] = 0;
        else if (!hold)            m_acc[i][c] = sat(acc + m_mult[i][c], p_aw(i));
        m_mult[i][c] = in_din(i, c) * m_twb[i][c];
        m_dind[i][c] = in_din(i, c);
        m_twb[i][c]  = m_twa[i][c];
        m_twa[i][c]  = in_tw(i, c);
      end
    m_tb = m_ta;
    m_ta = trig;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < CH; c++) begin
        check($sformatf("model dout i%0d c%0d", i, c), dut_dout(i, c), m_dout[i][c]);
        check($sformatf("model oflow i%0d c%0d", i, c), dut_flag(i, c), longint'(m_flag[i][c]));
      end
  endtask

  // One clock: model advances on the edge, outputs compared on the falling edge
  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic set_a(input int c, input int d, input int w);
    din_a[c*DWA +: DWA] = 16'(d);
    tw_a_in[c*TW +: TW] = 7'(w);
  endtask
  task automatic set_b(input int c, input int d, input int w);
    din_b[c*DWB +: DWB] = 8'(d);
    tw_b_in[c*TW +: TW] = 7'(w);
  endtask

  task automatic ctl_idle();
    trig = 1'b0; accClr_en = 1'b0; hold = 1'b0; bypass = 1'b0; oflow_clr = 1'b0;
  endtask

  // Assert reset with live, non-zero data; outputs must drop at once
  task automatic reset_on();
    rst_n = 1'b0;
    din_a = $urandom | 32'h1;
    din_b = 16'($urandom) | 16'h1;
    #1;
    model_reset();
    compare_model();
    tick();
    tick();
  endtask

  typedef struct {
    int d0, w0, d1, w1, n, e0, e1, ef;
  } vec_t;
  vec_t vecs [6];

  int prev_d, d, bias;
  int wa [CH];
  int wb [CH];

  initial begin
    vecs[0] = '{d0: 1000,   w0: 63, d1: 0,     w1: 5,   n: 14, e0: 1019,   e1: 0,      ef: 0};
    vecs[1] = '{d0: -1000,  w0: 63, d1: 500,   w1: -64, n: 14, e0: -1020,  e1: 490,    ef: 0};
    vecs[2] = '{d0: 32767,  w0: 63, d1: 0,     w1: 0,   n: 5,  e0: 32767,  e1: 0,      ef: 1};
    vecs[3] = '{d0: 100,    w0: 0,  d1: -32768, w1: -1, n: 20, e0: 100,    e1: -32752, ef: 0};
    vecs[4] = '{d0: 1000,   w0: 63, d1: -5,    w1: 3,   n: 4,  e0: 1000,   e1: -5,     ef: 0};
    vecs[5] = '{d0: -32768, w0: 63, d1: 32767, w1: -64, n: 5,  e0: -32768, e1: 32703,  ef: 1};

    rst_n = 1'b0; din_a = '0; din_b = '0; tw_a_in = '0; tw_b_in = '0;
    ctl_idle();
    model_reset();
    @(negedge clk);

    // Reset behaviour and first post-reset output
    reset_on();
    set_a(0, 1234, 63); set_a(1, -777, 10);
    rst_n = 1'b1;
    tick();
    check("first dout0 after reset", dut_dout(0, 0), 0);
    check("first dout1 after reset", dut_dout(0, 1), 0);

    // Vector table: steady inputs from reset, one output snapshot each
    for (int k = 0; k < 6; k++) begin
      reset_on();
      ctl_idle();
      set_a(0, vecs[k].d0, vecs[k].w0);
      set_a(1, vecs[k].d1, vecs[k].w1);
      rst_n = 1'b1;
      repeat (vecs[k].n) tick();
      check($sformatf("vec%0d dout0", k), dut_dout(0, 0), vecs[k].e0);
      check($sformatf("vec%0d dout1", k), dut_dout(0, 1), vecs[k].e1);
      check($sformatf("vec%0d oflow", k), longint'(ofl_a), vecs[k].ef);
    end

    // Clear on trig edge, held trig, ignored edge, clear beats hold
    reset_on();
    ctl_idle();
    set_a(0, 1000, 63); set_a(1, 0, 0);
    rst_n = 1'b1;
    repeat (14) tick();
    check("integrate 10 steps", dut_dout(0, 0), 1019);
    trig = 1'b1; accClr_en = 1'b1;
    repeat (2) tick();
    check("dout before clear seen", dut_dout(0, 0), 1023);
    tick();
    check("dout after clear", dut_dout(0, 0), 1000);
    repeat (10) tick();
    check("held trig clears once", dut_dout(0, 0), 1019);
    trig = 1'b0;
    repeat (2) tick();
    trig = 1'b1; accClr_en = 1'b0;
    repeat (3) tick();
    check("edge ignored without enable", dut_dout(0, 0), 1028);
    trig = 1'b0;
    repeat (2) tick();
    trig = 1'b1; accClr_en = 1'b1; hold = 1'b1;
    repeat (3) tick();
    check("clear wins over hold", dut_dout(0, 0), 1000);
    for (int j = 0; j < 20; j++) begin
      tick();
      check("hold freezes dout", dut_dout(0, 0), 1000);
    end
    ctl_idle();

    // Positive overflow, sticky flag, clear blocked while overflow persists
    reset_on();
    ctl_idle();
    set_a(0, 32767, 63); set_a(1, 0, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("pos sat dout", dut_dout(0, 0), 32767);
    check("pos sat flag", dut_flag(0, 0), 1);
    repeat (600) tick();
    set_a(0, 0, 63);
    repeat (5) tick();
    check("oflow dout after din=0", dut_dout(0, 0), 32767);
    check("flag sticky after din=0", dut_flag(0, 0), 1);
    oflow_clr = 1'b1;
    repeat (3) tick();
    check("clr blocked by oflow", dut_flag(0, 0), 1);
    check("ch1 flag isolated", dut_flag(0, 1), 0);
    oflow_clr = 1'b0; trig = 1'b1; accClr_en = 1'b1;
    repeat (4) tick();
    trig = 1'b0; oflow_clr = 1'b1;
    tick();
    check("flag cleared", dut_flag(0, 0), 0);
    check("dout zero after clear", dut_dout(0, 0), 0);
    ctl_idle();

    // Negative saturation on both widths; narrow accumulator hits its clamp
    reset_on();
    ctl_idle();
    set_a(0, -32768, 63); set_a(1, 0, 0);
    set_b(0, -128, 63);   set_b(1, 5, 1);
    rst_n = 1'b1;
    for (int j = 0; j < 2000; j++) begin
      tick();
      if (j >= 1) begin
        check("neg sat dout wide", dut_dout(0, 0), -32768);
        check("neg sat dout narrow", dut_dout(1, 0), -128);
      end
    end
    set_b(0, 127, 63);
    repeat (200) tick();

    // Bypass: two-cycle delay of din, accumulation continues, no flag
    reset_on();
    ctl_idle();
    set_a(0, 1000, 63); set_a(1, 0, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    bypass = 1'b1;
    prev_d = 1000;
    for (int j = 0; j < 20; j++) begin
      d = int'($urandom_range(0, 65535)) - 32768;
      set_a(0, d, 63);
      tick();
      check("bypass delay", dut_dout(0, 0), prev_d);
      prev_d = d;
    end
    set_a(0, 32767, 63);
    repeat (600) tick();
    check("bypass no flag", dut_flag(0, 0), 0);
    check("bypass passes din", dut_dout(0, 0), 32767);
    bypass = 1'b0;
    set_a(0, 0, 63);
    repeat (2) tick();
    check("acc grew in bypass", dut_dout(0, 0), 32767);
    check("flag after bypass", dut_flag(0, 0), 1);

    // Randomised run against the model, with an asynchronous reset mid-pulse
    reset_on();
    ctl_idle();
    rst_n = 1'b1;
    for (int c = 0; c < CH; c++) begin
      wa[c] = int'($urandom_range(0, 127)) - 64;
      wb[c] = int'($urandom_range(0, 127)) - 64;
    end
    bias = 0;
    for (int j = 0; j < 4000; j++) begin
      if (j % 400 == 0) bias = int'($urandom_range(0, 1));
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 49) == 0) wa[c] = int'($urandom_range(0, 127)) - 64;
        if ($urandom_range(0, 49) == 0) wb[c] = int'($urandom_range(0, 127)) - 64;
        d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                        : (bias != 0 ? 32767 : -32768);
        set_a(c, d, wa[c]);
        d = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) - 128
                                        : (bias != 0 ? 127 : -128);
        set_b(c, d, wb[c]);
      end
      if ($urandom_range(0, 5) == 0) trig = ~trig;
      accClr_en = 1'($urandom_range(0, 1));
      hold      = ($urandom_range(0, 9) == 0);
      bypass    = ($urandom_range(0, 9) == 0);
      oflow_clr = ($urandom_range(0, 7) == 0);
      if (j == 2000) begin
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
